uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Frame scheduler that shares the single UART transmit byte channel among four event sources: alarm, key-save, key-fetch and location/voice report. Each source posts a one-byte payload with a one-cycle request pulse. The arbiter queues one pending request per source, chooses a winner, and streams a 4-byte framed message to the byte-level UART transmitter over a valid/ready handshake. It sits between the event logic and the UART TX byte engine inside the RX/TX top level.

## Interface
Parameters:
- HEADER, 8'hAA, first byte of every frame
- TYPE_BASE, 8'h10, type byte = TYPE_BASE | source id
- GAP_CYCLES, 16, idle cycles enforced after each frame (0 = no gap)

Ports:
- clk  in  1  system clock; one clock domain
- rst_n  in  1  asynchronous active-low reset
- req  in  4  one-cycle request pulses; bit 0 alarm, 1 save, 2 fetch, 3 location
- payload0..payload3  in  8 each  payload for the matching source, sampled in the cycle its req bit is high
- tx_data  out  8  byte to the UART byte transmitter
- tx_valid  out  1  tx_data is valid
- tx_ready  in  1  transmitter accepts the byte when tx_valid && tx_ready
- busy  out  1  high from grant until the gap ends
- grant_id  out  2  source being served; holds its last value when idle
- frame_done  out  1  one-cycle pulse when the last byte is accepted
- drop  out  1  one-cycle pulse when a req hits an already-pending source

## Operation
- Pending store: one pending bit and one 8-bit payload register per source.
  - req[i] sets pending[i] and captures payload i.
  - If pending[i] is already set, the new payload overwrites the old one and drop pulses in the next cycle.
- Arbitration, evaluated only in IDLE:
  - Source 0 (alarm) has strict priority.
  - Sources 1–3 are served round-robin. The pointer holds the last source served from 1–3; the search starts at pointer+1 and wraps 3→1. The pointer resets to 3, so source 1 is searched first.
  - Serving source 0 does not move the pointer.
- Grant:
  - Copy the winner's payload into the frame register and clear its pending bit.
  - A req for the same source in the grant cycle re-sets pending with the new payload; the new request wins over the clear.
  - Build the frame: HEADER, TYPE_BASE|id, payload, checksum = (TYPE_BASE|id) ^ payload.
- FSM states:
  - IDLE → SEND on any pending bit.
  - SEND steps the byte index 0..3 on each accepted byte.
  - After byte 3 is accepted: frame_done pulses; go to GAP if GAP_CYCLES>0, else IDLE.
  - GAP counts GAP_CYCLES cycles, then → IDLE.
- Handshake rules:
  - Once tx_valid is asserted, tx_valid and tx_data stay stable until accepted.
  - tx_valid is never withdrawn mid-frame.
  - tx_valid is low in IDLE and GAP.
- Frames are never preempted; an alarm arriving mid-frame waits for the frame and the gap to finish.
- Reset asserted mid-frame:
  - Aborts immediately.
  - Pending bits, payload registers and pointer are cleared; the FSM returns to IDLE.
  - The partial frame is not resumed.

## Timing
- Reset values: tx_data 0, tx_valid 0, busy 0, grant_id 0, frame_done 0, drop 0, pending 0, pointer 3, FSM IDLE.
- Grant latency:
  - req pulse in cycle t sets pending at edge t+1.
  - Grant (busy=1, grant_id valid) at edge t+2.
  - tx_valid=1 with HEADER at edge t+2.
- Byte stepping:
  - With tx_ready tied high, one byte is accepted per cycle.
  - Bytes go out in cycles t+2..t+5; frame_done is high in cycle t+6.
- busy stays high through GAP. It deasserts GAP_CYCLES cycles after the frame_done cycle; then the next grant can occur the following cycle.
- drop pulses one cycle after the offending req.
- Simultaneous req pulses on several sources are all captured in the same cycle.

## Structure
- Shared package holds:
  - Source id constants: SRC_ALARM=0, SRC_SAVE=1, SRC_FETCH=2, SRC_LOC=3.
  - FSM state encoding: IDLE, SEND, GAP.
  - Defaults for HEADER and TYPE_BASE.
- One sub-module, rr_pick3: combinational round-robin selector over sources 1–3 given the pending bits and the pointer. It returns a valid flag and the chosen id.
- Pending store, frame builder and FSM live in the top of this block.

## Test plan
- Single alarm request: req=0001, payload0=8'h5A, tx_ready=1.
  - Expected tx sequence: AA, 10, 5A, 4A.
  - frame_done pulses in cycle t+6.
  - busy clears 16 cycles after frame_done.
- Simultaneous req=1110 with payloads 8'h01/8'h02/8'h03, followed by an alarm issued mid-first-frame.
  - Expected frame order: source 1, source 0, source 2, source 3.
  - Each frame is separated by a gap.
- Back-pressure: tx_ready low for 5 cycles on byte 2.
  - tx_valid and tx_data (payload) stay stable the whole time.
  - No byte is skipped or duplicated.
- Overwrite: two req[2] pulses (8'h11, then 8'h22) while a frame is busy.
  - drop pulses once.
  - The later frame carries 22, with checksum 8'h30.
- Reset mid-frame: assert rst_n=0 after byte 1 while another source is pending.
  - All outputs return to their reset values.
  - After release, no frame is sent until a new req arrives.

Source files
------------

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the UART TX frame arbiter.
package uart_tx_arbiter_pkg;

    localparam logic [1:0] SRC_ALARM = 2'd0;
    localparam logic [1:0] SRC_SAVE  = 2'd1;
    localparam logic [1:0] SRC_FETCH = 2'd2;
    localparam logic [1:0] SRC_LOC   = 2'd3;

    localparam logic [7:0] HEADER_DEFAULT    = 8'hAA;
    localparam logic [7:0] TYPE_BASE_DEFAULT = 8'h10;

    localparam int NUM_SRC     = 4;
    localparam int FRAME_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    // Round-robin successor within sources 1..3; 3 wraps back to 1.
    function automatic logic [1:0] rr_next(input logic [1:0] id);
        return (id == SRC_LOC) ? SRC_SAVE : 2'(id + 2'd1);
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick3.sv
// Combinational round-robin selector over sources 1..3, starting after i_ptr.
module rr_pick3
    import uart_tx_arbiter_pkg::*;
(
    input  logic [3:1] i_pending,
    input  logic [1:0] i_ptr,
    output logic       o_valid,
    output logic [1:0] o_id
);

    always_comb begin
        logic [1:0] cand;
        logic       hit;
        o_valid = 1'b0;
        o_id    = SRC_SAVE;
        cand    = i_ptr;
        hit     = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cand = rr_next(cand);
            case (cand)
                SRC_SAVE:  hit = i_pending[1];
                SRC_FETCH: hit = i_pending[2];
                SRC_LOC:   hit = i_pending[3];
                default:   hit = 1'b0;
            endcase
            if (hit && !o_valid) begin
                o_valid = 1'b1;
                o_id    = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the UART TX byte channel among four event sources, sending
// 4-byte frames (header, type, payload, checksum) with an idle gap after each.
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | no frame in flight; arbitrate pending sources each cycle
// ST_SEND | streaming frame bytes 0..3 over the valid/ready handshake
// ST_GAP  | enforced idle spacing after a frame; busy stays high
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter logic [7:0] HEADER     = HEADER_DEFAULT,
    parameter logic [7:0] TYPE_BASE  = TYPE_BASE_DEFAULT,
    parameter int         GAP_CYCLES = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_req,
    input  logic [7:0] i_payload0,
    input  logic [7:0] i_payload1,
    input  logic [7:0] i_payload2,
    input  logic [7:0] i_payload3,
    output logic [7:0] o_tx_data,
    output logic       o_tx_valid,
    input  logic       i_tx_ready,
    output logic       o_busy,
    output logic [1:0] o_grant_id,
    output logic       o_frame_done,
    output logic       o_drop
);

    localparam logic [15:0] GAP_LOAD = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

    arb_state_t r_state;
    arb_state_t w_state_nxt;

    logic [3:0]  r_pending;
    logic [7:0]  r_payload [NUM_SRC];
    logic [1:0]  r_ptr;
    logic [1:0]  r_grant_id;
    logic [7:0]  r_frame_pay;
    logic [1:0]  r_byte_idx;
    logic [15:0] r_gap_cnt;
    logic        r_frame_done;
    logic        r_drop;

    logic [7:0]  w_pay_in [NUM_SRC];
    logic        w_rr_valid;
    logic [1:0]  w_rr_id;
    logic        w_any;
    logic        w_grant;
    logic [1:0]  w_win;
    logic [3:0]  w_clr_mask;
    logic        w_accept;
    logic        w_last_accept;
    logic [7:0]  w_type;
    logic [7:0]  w_byte;

    assign w_pay_in[0] = i_payload0;
    assign w_pay_in[1] = i_payload1;
    assign w_pay_in[2] = i_payload2;
    assign w_pay_in[3] = i_payload3;

    rr_pick3 u_rr_pick3 (
        .i_pending (r_pending[3:1]),
        .i_ptr     (r_ptr),
        .o_valid   (w_rr_valid),
        .o_id      (w_rr_id)
    );

    // Alarm has strict priority and never disturbs the round-robin pointer.
    assign w_any         = r_pending[SRC_ALARM] | w_rr_valid;
    assign w_win         = r_pending[SRC_ALARM] ? SRC_ALARM : w_rr_id;
    assign w_grant       = (r_state == ST_IDLE) && w_any;
    assign w_clr_mask    = w_grant ? (4'b0001 << w_win) : 4'b0000;
    assign w_accept      = (r_state == ST_SEND) && i_tx_ready;
    assign w_last_accept = w_accept && (r_byte_idx == 2'(FRAME_BYTES - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_any) w_state_nxt = ST_SEND;
            ST_SEND: if (w_last_accept) w_state_nxt = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;
            ST_GAP:  if (r_gap_cnt == 16'd0) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_type = TYPE_BASE | {6'd0, r_grant_id};

    always_comb begin
        w_byte = HEADER;
        case (r_byte_idx)
            2'd0:    w_byte = HEADER;
            2'd1:    w_byte = w_type;
            2'd2:    w_byte = r_frame_pay;
            2'd3:    w_byte = w_type ^ r_frame_pay;
            default: w_byte = HEADER;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_pending    <= 4'b0000;
            for (int i = 0; i < NUM_SRC; i++) r_payload[i] <= 8'h00;
            r_ptr        <= SRC_LOC;
            r_grant_id   <= SRC_ALARM;
            r_frame_pay  <= 8'h00;
            r_byte_idx   <= 2'd0;
            r_gap_cnt    <= 16'd0;
            r_frame_done <= 1'b0;
            r_drop       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= w_last_accept;
            // A req on the source being granted re-arms it rather than dropping.
            r_drop       <= |(i_req & r_pending & ~w_clr_mask);
            r_pending    <= (r_pending & ~w_clr_mask) | i_req;
            for (int i = 0; i < NUM_SRC; i++) begin
                if (i_req[i]) r_payload[i] <= w_pay_in[i];
            end
            if (w_grant) begin
                r_grant_id  <= w_win;
                r_frame_pay <= r_payload[w_win];
                if (w_win != SRC_ALARM) r_ptr <= w_win;
            end
            if (w_grant) begin
                r_byte_idx <= 2'd0;
            end else if (w_accept) begin
                r_byte_idx <= 2'(r_byte_idx + 2'd1);
            end
            if (w_last_accept) begin
                r_gap_cnt <= GAP_LOAD;
            end else if ((r_state == ST_GAP) && (r_gap_cnt != 16'd0)) begin
                r_gap_cnt <= r_gap_cnt - 16'd1;
            end
        end
    end

    assign o_tx_valid   = (r_state == ST_SEND);
    assign o_tx_data    = (r_state == ST_SEND) ? w_byte : 8'h00;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_grant_id   = r_grant_id;
    assign o_frame_done = r_frame_done;
    assign o_drop       = r_drop;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed frame vectors, corner sequences and
// randomized traffic checked every cycle against a frame-level reference model.
module tb_uart_tx_arbiter;

    localparam int GAP = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [7:0] pl [4];
    logic       ready = 1'b1;

    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       o_busy;
    logic [1:0] o_grant_id;
    logic       o_frame_done;
    logic       o_drop;

    uart_tx_arbiter #(.HEADER(8'hAA), .TYPE_BASE(8'h10), .GAP_CYCLES(GAP)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req        (req),
        .i_payload0   (pl[0]),
        .i_payload1   (pl[1]),
        .i_payload2   (pl[2]),
        .i_payload3   (pl[3]),
        .o_tx_data    (o_tx_data),
        .o_tx_valid   (o_tx_valid),
        .i_tx_ready   (ready),
        .o_busy       (o_busy),
        .o_grant_id   (o_grant_id),
        .o_frame_done (o_frame_done),
        .o_drop       (o_drop)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int done_cyc = -1;
    int fall_cyc = -1;
    int drop_cnt = 0;
    logic busy_q = 1'b0;
    logic [7:0] acc_q [$];

    // Reference model: per-source pending slots plus the frame currently on the wire.
    bit         m_pend [4];
    logic [7:0] m_pay [4];
    int         m_ptr;
    int         m_phase;   // 0 idle, 1 sending, 2 gap
    int         m_idx;
    int         m_gap;
    int         m_gid;
    logic [7:0] m_frame [4];
    bit         m_done;
    bit         m_drop;

    typedef struct {
        int         src;
        logic [7:0] pay;
        logic [7:0] typ;
        logic [7:0] cks;
    } vec_t;
    vec_t tbl [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_pend[i] = 0;
            m_pay[i]  = 8'h00;
        end
        m_ptr = 3; m_phase = 0; m_idx = 0; m_gap = 0; m_gid = 0;
        m_done = 0; m_drop = 0;
    endtask

    task automatic model_step();
        int win;
        logic [7:0] t;
        win = -1;
        if (m_phase == 0) begin
            if (m_pend[0]) win = 0;
            else begin
                for (int k = 1; k <= 3; k++) begin
                    int c;
                    c = (m_ptr + k - 1) % 3 + 1;
                    if (win < 0 && m_pend[c]) win = c;
                end
            end
        end
        m_done = 0;
        m_drop = 0;
        if (m_phase == 0) begin
            if (win >= 0) begin
                t = 8'h10 | 8'(win);
                m_frame[0] = 8'hAA;
                m_frame[1] = t;
                m_frame[2] = m_pay[win];
                m_frame[3] = t ^ m_pay[win];
                m_phase = 1; m_idx = 0; m_gid = win;
                if (win != 0) m_ptr = win;
            end
        end else if (m_phase == 1) begin
            if (ready) begin
                if (m_idx == 3) begin
                    m_done = 1;
                    if (GAP > 0) begin m_phase = 2; m_gap = GAP; end
                    else m_phase = 0;
                end else m_idx++;
            end
        end else begin
            m_gap--;
            if (m_gap == 0) m_phase = 0;
        end
        for (int i = 0; i < 4; i++) begin
            if (win == i) m_pend[i] = 0;
            if (req[i] && m_pend[i]) m_drop = 1;
            if (req[i]) begin
                m_pend[i] = 1;
                m_pay[i]  = pl[i];
            end
        end
    endtask

    task automatic step();
        if (rst_n && o_tx_valid && ready) acc_q.push_back(o_tx_data);
        @(posedge clk);
        if (rst_n) model_step();
        cyc++;
        #1;
        chk("tx_valid", o_tx_valid, m_phase == 1);
        chk("busy", o_busy, m_phase != 0);
        chk("grant_id", o_grant_id, m_gid);
        chk("frame_done", o_frame_done, m_done);
        chk("drop", o_drop, m_drop);
        if (m_phase == 1) chk("tx_data", o_tx_data, m_frame[m_idx]);
        if (o_frame_done) done_cyc = cyc;
        if (busy_q && !o_busy) fall_cyc = cyc;
        busy_q = o_busy;
        if (o_drop) drop_cnt++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse(input logic [3:0] m, input logic [7:0] p0, input logic [7:0] p1,
                         input logic [7:0] p2, input logic [7:0] p3);
        req = m; pl[0] = p0; pl[1] = p1; pl[2] = p2; pl[3] = p3;
        step();
        req = 4'b0000;
    endtask

    task automatic pulse1(input int src, input logic [7:0] p);
        pl[src] = p;
        req = 4'(1 << src);
        step();
        req = 4'b0000;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req = 4'b0000;
        model_reset();
        #1;
        chk("rst_tx_data", o_tx_data, 8'h00);
        chk("rst_tx_valid", o_tx_valid, 1'b0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_grant_id", o_grant_id, 2'd0);
        chk("rst_frame_done", o_frame_done, 1'b0);
        chk("rst_drop", o_drop, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        busy_q = 1'b0;
        acc_q.delete();
    endtask

    task automatic chk_frame(input string nm, input int b, input logic [7:0] typ,
                             input logic [7:0] pay, input logic [7:0] cks);
        if (acc_q.size() < b + 4) begin
            chk({nm, "_len"}, acc_q.size(), b + 4);
            return;
        end
        chk({nm, "_hdr"}, acc_q[b], 8'hAA);
        chk({nm, "_type"}, acc_q[b+1], typ);
        chk({nm, "_payload"}, acc_q[b+2], pay);
        chk({nm, "_checksum"}, acc_q[b+3], cks);
    endtask

    initial begin
        int t0;
        tbl[0] = '{src: 0, pay: 8'h5A, typ: 8'h10, cks: 8'h4A};
        tbl[1] = '{src: 1, pay: 8'h3C, typ: 8'h11, cks: 8'h2D};
        tbl[2] = '{src: 2, pay: 8'hFF, typ: 8'h12, cks: 8'hED};
        tbl[3] = '{src: 3, pay: 8'h00, typ: 8'h13, cks: 8'h13};
        tbl[4] = '{src: 0, pay: 8'h10, typ: 8'h10, cks: 8'h00};
        for (int i = 0; i < 4; i++) pl[i] = 8'h00;

        do_reset();

        // Single alarm: byte sequence, frame_done latency and gap length.
        run(2);
        t0 = cyc;
        done_cyc = -1; fall_cyc = -1;
        pulse1(0, 8'h5A);
        run(30);
        chk("alarm_bytes", acc_q.size(), 4);
        chk_frame("alarm", 0, 8'h10, 8'h5A, 8'h4A);
        chk("alarm_done_cycle", done_cyc - t0, 6);
        chk("alarm_gap", fall_cyc - done_cyc, GAP);

        // Table of single-source frames.
        for (int v = 0; v < 5; v++) begin
            acc_q.delete();
            pulse1(tbl[v].src, tbl[v].pay);
            run(25);
            chk("vec_bytes", acc_q.size(), 4);
            chk_frame("vec", 0, tbl[v].typ, tbl[v].pay, tbl[v].cks);
        end

        // Simultaneous 1/2/3 requests plus an alarm arriving mid-frame.
        do_reset();
        pulse(4'b1110, 8'h00, 8'h01, 8'h02, 8'h03);
        run(3);
        pulse(4'b0001, 8'h77, 8'h00, 8'h00, 8'h00);
        run(100);
        chk("order_bytes", acc_q.size(), 16);
        chk_frame("order_f1", 0, 8'h11, 8'h01, 8'h10);
        chk_frame("order_f2", 4, 8'h10, 8'h77, 8'h67);
        chk_frame("order_f3", 8, 8'h12, 8'h02, 8'h10);
        chk_frame("order_f4", 12, 8'h13, 8'h03, 8'h10);

        // Back-pressure on the payload byte.
        acc_q.delete();
        pulse1(2, 8'h3C);
        run(3);
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp_valid", o_tx_valid, 1'b1);
            chk("bp_data", o_tx_data, 8'h3C);
        end
        ready = 1'b1;
        run(25);
        chk("bp_bytes", acc_q.size(), 4);
        chk_frame("bp", 0, 8'h12, 8'h3C, 8'h2E);

        // Overwrite of a pending source while another frame is busy.
        acc_q.delete();
        drop_cnt = 0;
        pulse1(0, 8'h01);
        run(4);
        pulse1(2, 8'h11);
        pulse1(2, 8'h22);
        run(60);
        chk("ovw_drop_count", drop_cnt, 1);
        chk("ovw_bytes", acc_q.size(), 8);
        chk_frame("ovw_f1", 0, 8'h10, 8'h01, 8'h11);
        chk_frame("ovw_f2", 4, 8'h12, 8'h22, 8'h30);

        // Reset after byte 1 with another source still pending.
        pulse(4'b1010, 8'h00, 8'h55, 8'h00, 8'h66);
        run(3);
        do_reset();
        run(40);
        chk("rst_no_frame", acc_q.size(), 0);
        chk("rst_idle_busy", o_busy, 1'b0);
        pulse1(3, 8'h44);
        run(30);
        chk("post_rst_bytes", acc_q.size(), 4);
        chk_frame("post_rst", 0, 8'h13, 8'h44, 8'h57);

        // Randomized traffic with random back-pressure.
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < 4; i++) begin
                pl[i]  = 8'($urandom);
                req[i] = ($urandom_range(0, 9) == 0);
            end
            ready = ($urandom_range(0, 3) != 0);
            step();
        end
        req = 4'b0000;
        ready = 1'b1;
        run(130);
        chk("drain_idle", o_busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
